// File: rtl/turbofm_pkg.sv
// Shared types and default timing for the YM2203 bus sequencer.
//   seq_state_e : sequencer phases
//   ym_acc_t    : one latched bus access (direction, A0, chip select, write data)
//   *Def        : default phase lengths in fclk cycles (fclk = 28 MHz, YM clock = fclk/8)
package turbofm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecover
    } seq_state_e;

    typedef struct packed {
        logic       wr;
        logic       a0;
        logic       chip;
        logic [7:0] data;
    } ym_acc_t;

    localparam int unsigned SetupDef   = 2;
    localparam int unsigned PulseDef   = 4;
    localparam int unsigned HoldDef    = 2;
    localparam int unsigned AdrWaitDef = 136;  // 17 YM clocks
    localparam int unsigned DatWaitDef = 664;  // 83 YM clocks

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ym_bus_seq.sv
// Timing sequencer driving the shared YM2203 bus for two chips.
// Each request runs SETUP -> STROBE -> HOLD, and writes add a RECOVER phase that
// covers the chip busy interval so upstream never polls the status register.
// Ports:
//   fclk, rst                 : clock, synchronous active-high reset
//   req, req_wr, req_a0,
//   req_chip, req_data        : access request (held until ack) and its fields
//   ack                       : one-cycle pulse on the last HOLD cycle
//   rd_data                   : last read result
//   busy                      : sequencer not idle
//   ymcs1_n, ymcs2_n,
//   ymrd_n, ymwr_n, yma0      : YM bus controls
//   d_out, d_oe, d_in         : YM data bus write value, drive enable, read value
module ym_bus_seq
    import turbofm_pkg::*;
#(
    parameter int unsigned SETUP    = SetupDef,
    parameter int unsigned PULSE    = PulseDef,
    parameter int unsigned HOLD     = HoldDef,
    parameter int unsigned ADR_WAIT = AdrWaitDef,
    parameter int unsigned DAT_WAIT = DatWaitDef
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_wr,
    input  logic       req_a0,
    input  logic       req_chip,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       ymcs1_n,
    output logic       ymcs2_n,
    output logic       ymrd_n,
    output logic       ymwr_n,
    output logic       yma0,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    localparam int unsigned MaxAll =
        max_u(max_u(max_u(SETUP, PULSE), max_u(HOLD, ADR_WAIT)), DAT_WAIT);
    localparam int unsigned CntW = $clog2(MaxAll + 1);

    seq_state_e      state;
    logic [CntW-1:0] cnt;
    ym_acc_t         acc;

    // Address and write data come straight from the latched access, so they are
    // stable for the whole time a chip select is low.
    assign yma0  = acc.a0;
    assign d_out = acc.data;

    always_ff @(posedge fclk) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            acc     <= '0;
            ack     <= 1'b0;
            rd_data <= '0;
            busy    <= 1'b0;
            ymcs1_n <= 1'b1;
            ymcs2_n <= 1'b1;
            ymrd_n  <= 1'b1;
            ymwr_n  <= 1'b1;
            d_oe    <= 1'b0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        acc     <= '{wr: req_wr, a0: req_a0, chip: req_chip, data: req_data};
                        state   <= StSetup;
                        cnt     <= CntW'(SETUP - 1);
                        busy    <= 1'b1;
                        ymcs1_n <= req_chip;
                        ymcs2_n <= ~req_chip;
                        d_oe    <= req_wr;
                    end
                end
                StSetup: begin
                    if (cnt == '0) begin
                        state   <= StStrobe;
                        cnt     <= CntW'(PULSE - 1);
                        ymcs1_n <= acc.chip;
                        ymcs2_n <= ~acc.chip;
                        ymwr_n  <= ~acc.wr;
                        ymrd_n  <= acc.wr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StStrobe: begin
                    if (cnt == '0) begin
                        state   <= StHold;
                        cnt     <= CntW'(HOLD - 1);
                        ymwr_n  <= 1'b1;
                        ymrd_n  <= 1'b1;
                        ymcs1_n <= 1'b1;
                        ymcs2_n <= 1'b1;
                        if (!acc.wr) begin
                            rd_data <= d_in;
                        end
                        // A single HOLD cycle is also the ack cycle.
                        ack <= (HOLD == 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StHold: begin
                    if (cnt == '0) begin
                        if (acc.wr) begin
                            state <= StRecover;
                            cnt   <= acc.a0 ? CntW'(DAT_WAIT - 1) : CntW'(ADR_WAIT - 1);
                            d_oe  <= 1'b0;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        ack <= (cnt == CntW'(1));
                    end
                end
                StRecover: begin
                    if (cnt == '0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ym_bus_seq.sv
// Self-checking bench for ym_bus_seq: stimulus pushes expected accesses into a
// scoreboard queue, a negedge monitor measures bus activity and checks each ack.
module tb_ym_bus_seq;

    localparam int P_SETUP = 2;
    localparam int P_PULSE = 4;
    localparam int P_HOLD  = 2;
    localparam int P_ADR   = 136;
    localparam int P_DAT   = 664;

    logic       fclk = 1'b0;
    logic       rst;
    logic       req, req_wr, req_a0, req_chip;
    logic [7:0] req_data, d_in;
    logic       ack, busy, ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0, d_oe;
    logic [7:0] rd_data, d_out;

    logic       s_req, s_wr, s_a0, s_chip;
    logic [7:0] s_data, s_din;
    logic       s_ack, s_busy, s_cs1_n, s_cs2_n, s_rd_n, s_wr_n, s_a0_o, s_oe;
    logic [7:0] s_rd_data, s_dout;

    always #5 fclk = ~fclk;

    int cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    ym_bus_seq u_dut (
        .fclk(fclk), .rst(rst), .req(req), .req_wr(req_wr), .req_a0(req_a0),
        .req_chip(req_chip), .req_data(req_data), .ack(ack), .rd_data(rd_data),
        .busy(busy), .ymcs1_n(ymcs1_n), .ymcs2_n(ymcs2_n), .ymrd_n(ymrd_n),
        .ymwr_n(ymwr_n), .yma0(yma0), .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    ym_bus_seq #(.SETUP(1), .PULSE(1), .HOLD(1), .ADR_WAIT(1)) u_small (
        .fclk(fclk), .rst(rst), .req(s_req), .req_wr(s_wr), .req_a0(s_a0),
        .req_chip(s_chip), .req_data(s_data), .ack(s_ack), .rd_data(s_rd_data),
        .busy(s_busy), .ymcs1_n(s_cs1_n), .ymcs2_n(s_cs2_n), .ymrd_n(s_rd_n),
        .ymwr_n(s_wr_n), .yma0(s_a0_o), .d_out(s_dout), .d_oe(s_oe), .d_in(s_din)
    );

    typedef struct {
        logic       wr;
        logic       a0;
        logic       chip;
        logic [7:0] data;
        logic [7:0] din;
        int         ack_edge;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   next_free = 0;  // earliest edge at which the model can accept a request

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int         c1, c2, wl, rl, oe_cnt, bcnt, bpend;
    bit         trk, cs_prev;
    logic       ref_a0;
    logic [7:0] ref_d, last_rd;

    always @(negedge fclk) begin
        if (rst) begin
            c1 = 0; c2 = 0; wl = 0; rl = 0; oe_cnt = 0;
            trk = 0; cs_prev = 0; last_rd = 8'h00;
            exp_q.delete();
        end else begin
            if (trk) begin
                if (busy) bcnt++;
                else begin
                    chk("busy_after_ack", bcnt, bpend);
                    trk = 0;
                end
            end
            chk("two_cs_low", int'(!ymcs1_n && !ymcs2_n), 0);
            chk("rd_wr_both_low", int'(!ymrd_n && !ymwr_n), 0);
            if (!ymcs1_n || !ymcs2_n) begin
                if (cs_prev) begin
                    chk("a0_stable", int'(yma0), int'(ref_a0));
                    chk("dout_stable", int'(d_out), int'(ref_d));
                end else begin
                    ref_a0 = yma0;
                    ref_d  = d_out;
                end
                cs_prev = 1;
            end else begin
                cs_prev = 0;
            end
            if (!ymcs1_n) c1++;
            if (!ymcs2_n) c2++;
            if (!ymwr_n) wl++;
            if (!ymrd_n) rl++;
            if (d_oe) oe_cnt++;
            if (ack) begin
                chk("ack_has_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_edge", cyc, e.ack_edge);
                    chk("cs_sel_cycles", e.chip ? c2 : c1, P_SETUP + P_PULSE);
                    chk("cs_other_cycles", e.chip ? c1 : c2, 0);
                    chk("strobe_cycles", e.wr ? wl : rl, P_PULSE);
                    chk("strobe_other_cycles", e.wr ? rl : wl, 0);
                    chk("yma0", int'(ref_a0), int'(e.a0));
                    chk("d_out", int'(ref_d), int'(e.data));
                    chk("d_oe_cycles", oe_cnt, e.wr ? (P_SETUP + P_PULSE + P_HOLD) : 0);
                    if (!e.wr) last_rd = e.din;
                    chk("rd_data", int'(rd_data), int'(last_rd));
                    chk("busy_at_ack", int'(busy), 1);
                    bpend = e.wr ? (e.a0 ? P_DAT : P_ADR) : 0;
                    bcnt  = 0;
                    trk   = 1;
                end
                c1 = 0; c2 = 0; wl = 0; rl = 0; oe_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge on which ack is seen (or after drop/gap).
    task automatic run_acc(input logic wr, input logic a0, input logic chip,
                           input logic [7:0] data, input logic [7:0] din,
                           input bit b2b, output int ack_at);
        int   t0;
        bit   got;
        exp_t e;
        req_wr = wr; req_a0 = a0; req_chip = chip; req_data = data; d_in = din;
        req = 1'b1;
        t0 = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        next_free = t0 + P_SETUP + P_PULSE + P_HOLD + 1 + (wr ? (a0 ? P_DAT : P_ADR) : 0);
        e.wr = wr; e.a0 = a0; e.chip = chip; e.data = data; e.din = din;
        e.ack_edge = t0 + P_SETUP + P_PULSE + P_HOLD - 1;
        exp_q.push_back(e);
        got = 0;
        ack_at = -1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge fclk);
            if (ack) begin
                got = 1;
                ack_at = cyc;
            end else if (cyc >= t0) begin
                // Access is latched; wiggling the request fields must not reach the bus.
                req_wr   = 1'($urandom_range(0, 1));
                req_a0   = 1'($urandom_range(0, 1));
                req_chip = 1'($urandom_range(0, 1));
                req_data = 8'($urandom_range(0, 255));
            end
        end
        chk("ack_seen", int'(got), 1);
        if (!b2b) begin
            req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge fclk);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs1_n"}, int'(ymcs1_n), 1);
        chk({tag, "_cs2_n"}, int'(ymcs2_n), 1);
        chk({tag, "_rd_n"}, int'(ymrd_n), 1);
        chk({tag, "_wr_n"}, int'(ymwr_n), 1);
        chk({tag, "_d_oe"}, int'(d_oe), 0);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_yma0"}, int'(yma0), 0);
        chk({tag, "_d_out"}, int'(d_out), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
    endtask

    initial begin
        int a1, a2, t0, sa, n;
        bit to;
        rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_a0 = 1'b0; req_chip = 1'b0;
        req_data = 8'h00; d_in = 8'h00;
        s_req = 1'b0; s_wr = 1'b0; s_a0 = 1'b0; s_chip = 1'b0; s_data = 8'h00; s_din = 8'h00;
        repeat (3) @(negedge fclk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        next_free = cyc + 1;

        // Address write, then data write with a request raised right after its ack.
        run_acc(1'b1, 1'b0, 1'b0, 8'h27, 8'h00, 1'b0, a1);
        run_acc(1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 1'b1, a1);
        // Back-to-back reads: status from chip 0, data from chip 1.
        run_acc(1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, a1);
        run_acc(1'b0, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b0, a2);
        chk("rd_ack_spacing", a2 - a1, P_SETUP + P_PULSE + P_HOLD + 1);

        // Reset during the strobe of a data write.
        req_wr = 1'b1; req_a0 = 1'b1; req_chip = 1'b1; req_data = 8'hC3; req = 1'b1;
        t0 = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        to = 1;
        for (int i = 0; i < 2000 && to; i++) begin
            @(negedge fclk);
            if (cyc >= t0 + P_SETUP + 1) to = 0;
        end
        chk("reach_strobe", int'(to), 0);
        chk("in_strobe_wr_n", int'(ymwr_n), 0);
        rst = 1'b1; req = 1'b0;
        @(negedge fclk);
        chk_reset_outputs("abort");
        @(negedge fclk);
        rst = 1'b0;
        next_free = cyc + 1;
        run_acc(1'b1, 1'b0, 1'b1, 8'h99, 8'h00, 1'b0, a1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic w, a, c;
            w = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            run_acc(w, a, c, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), a1);
        end
        req = 1'b0;

        // Minimum-timing instance: address write then read.
        s_wr = 1'b1; s_a0 = 1'b0; s_chip = 1'b0; s_data = 8'h11; s_req = 1'b1;
        t0 = cyc + 1; sa = -1; n = 0;
        for (int i = 0; i < 50 && sa < 0; i++) begin
            @(negedge fclk);
            if (!s_wr_n) n++;
            if (s_ack) sa = cyc;
        end
        s_req = 1'b0;
        chk("small_wr_ack_latency", sa - t0, 2);
        chk("small_wr_strobe", n, 1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge fclk);
            if (!s_busy) break;
            n++;
        end
        chk("small_recover_cycles", n, 1);
        s_wr = 1'b0; s_din = 8'hA5; s_req = 1'b1;
        t0 = cyc + 1; sa = -1;
        for (int i = 0; i < 50 && sa < 0; i++) begin
            @(negedge fclk);
            if (s_ack) sa = cyc;
        end
        s_req = 1'b0;
        chk("small_rd_ack_latency", sa - t0, 2);
        chk("small_rd_data", int'(s_rd_data), 8'hA5);

        repeat (P_DAT + 20) @(negedge fclk);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_tracking_done", int'(trk), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
